traffic_light_monitor: RTL and testbench

- Passive checker on the receiving end of the four light buses (light_M1, light_M2, light_MT, light_S) that the intersection controller drives.
- Decodes each sampled light pattern back into a phase index (0..5).
- Tracks phase order and per-phase dwell time against the controller's fixed timing.
- Raises a sticky fault with a cause code on the first violation; used in simulation benches and as an on-chip safety watchdog.

---
 rtl/traffic_light_monitor.sv | 181 ++++++++++++++++++
 tb/tb_traffic_light_monitor.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/traffic_light_monitor.sv
// Passive checker for the intersection light buses: decodes each sampled pattern into a phase,
// then checks phase order and per-phase dwell time. The first violation latches a sticky fault.
module traffic_light_monitor #(
  parameter int unsigned DWELL_P0 = 8,
  parameter int unsigned DWELL_P1 = 3,
  parameter int unsigned DWELL_P2 = 6,
  parameter int unsigned DWELL_P3 = 3,
  parameter int unsigned DWELL_P4 = 4,
  parameter int unsigned DWELL_P5 = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] light_M1,
  input  logic [2:0] light_M2,
  input  logic [2:0] light_MT,
  input  logic [2:0] light_S,
  input  logic       clr,
  output logic [2:0] phase_id,
  output logic       phase_valid,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [3:0] dwell_cnt,
  output logic [7:0] cycle_cnt
);

  localparam logic [2:0] LampR = 3'b100;
  localparam logic [2:0] LampY = 3'b010;
  localparam logic [2:0] LampG = 3'b001;

  localparam logic [2:0] CodeNone    = 3'd0;
  localparam logic [2:0] CodeIllegal = 3'd1;
  localparam logic [2:0] CodeOrder   = 3'd2;
  localparam logic [2:0] CodeShort   = 3'd3;
  localparam logic [2:0] CodeLong    = 3'd4;

  typedef enum logic [1:0] {
    StSync  = 2'd0,
    StTrack = 2'd1,
    StFault = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] phase_q, phase_d;
  logic [3:0] dwell_q, dwell_d;
  logic [7:0] cycle_q, cycle_d;
  logic       fault_q, fault_d;
  logic [2:0] code_q, code_d;
  logic       first_q, first_d;

  logic [11:0] lamps;
  logic        legal;
  logic [2:0]  dec_phase;
  logic [2:0]  succ_phase;
  logic [3:0]  req_cur;
  logic [3:0]  dwell_inc;

  assign lamps = {light_M1, light_M2, light_MT, light_S};

  // Exact match against the six controller patterns; everything else is illegal.
  always_comb begin
    legal     = 1'b1;
    dec_phase = 3'd0;
    unique case (lamps)
      {LampG, LampG, LampR, LampR}: dec_phase = 3'd0;
      {LampG, LampY, LampR, LampR}: dec_phase = 3'd1;
      {LampG, LampR, LampG, LampR}: dec_phase = 3'd2;
      {LampY, LampR, LampY, LampR}: dec_phase = 3'd3;
      {LampR, LampR, LampR, LampG}: dec_phase = 3'd4;
      {LampR, LampR, LampR, LampY}: dec_phase = 3'd5;
      default:                      legal     = 1'b0;
    endcase
  end

  always_comb begin
    req_cur = 4'(DWELL_P0);
    unique case (phase_q)
      3'd0:    req_cur = 4'(DWELL_P0);
      3'd1:    req_cur = 4'(DWELL_P1);
      3'd2:    req_cur = 4'(DWELL_P2);
      3'd3:    req_cur = 4'(DWELL_P3);
      3'd4:    req_cur = 4'(DWELL_P4);
      3'd5:    req_cur = 4'(DWELL_P5);
      default: req_cur = 4'(DWELL_P0);
    endcase
  end

  assign succ_phase = (phase_q == 3'd5) ? 3'd0 : phase_q + 3'd1;
  assign dwell_inc  = (dwell_q == 4'd15) ? 4'd15 : dwell_q + 4'd1;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    dwell_d = dwell_q;
    cycle_d = cycle_q;
    fault_d = fault_q;
    code_d  = code_q;
    first_d = first_q;
    unique case (state_q)
      StSync: begin
        if (legal) begin
          state_d = StTrack;
          phase_d = dec_phase;
          dwell_d = 4'd1;
          first_d = 1'b1;
        end else begin
          state_d = StFault;
          fault_d = 1'b1;
          code_d  = CodeIllegal;
        end
      end
      StTrack: begin
        if (!legal) begin
          state_d = StFault;
          fault_d = 1'b1;
          code_d  = CodeIllegal;
        end else if (dec_phase != phase_q) begin
          if (dec_phase != succ_phase) begin
            state_d = StFault;
            fault_d = 1'b1;
            code_d  = CodeOrder;
          end else if ((dwell_q < req_cur) && !first_q) begin
            state_d = StFault;
            fault_d = 1'b1;
            code_d  = CodeShort;
          end else begin
            phase_d = dec_phase;
            dwell_d = 4'd1;
            first_d = 1'b0;
            if (phase_q == 3'd5) begin
              cycle_d = cycle_q + 8'd1;
            end
          end
        end else if (dwell_q >= req_cur) begin
          // Long check applies even to a phase we attached to mid-way.
          state_d = StFault;
          fault_d = 1'b1;
          code_d  = CodeLong;
        end else begin
          dwell_d = dwell_inc;
        end
      end
      StFault: begin
        if (clr) begin
          state_d = StSync;
          fault_d = 1'b0;
          code_d  = CodeNone;
          dwell_d = 4'd0;
        end
      end
      default: state_d = StSync;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StSync;
      phase_q <= 3'd0;
      dwell_q <= 4'd0;
      cycle_q <= 8'd0;
      fault_q <= 1'b0;
      code_q  <= CodeNone;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      dwell_q <= dwell_d;
      cycle_q <= cycle_d;
      fault_q <= fault_d;
      code_q  <= code_d;
      first_q <= first_d;
    end
  end

  assign phase_id    = phase_q;
  assign phase_valid = (state_q == StTrack);
  assign fault       = fault_q;
  assign fault_code  = code_q;
  assign dwell_cnt   = dwell_q;
  assign cycle_cnt   = cycle_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor: legal cycles, each fault cause, clr and async reset.
module tb_traffic_light_monitor;

  logic       clk;
  logic       rst;
  logic [2:0] light_M1, light_M2, light_MT, light_S;
  logic       clr;
  logic [2:0] phase_id;
  logic       phase_valid;
  logic       fault;
  logic [2:0] fault_code;
  logic [3:0] dwell_cnt;
  logic [7:0] cycle_cnt;

  int n_chk;
  int n_bad;

  traffic_light_monitor dut (
    .clk        (clk),
    .rst        (rst),
    .light_M1   (light_M1),
    .light_M2   (light_M2),
    .light_MT   (light_MT),
    .light_S    (light_S),
    .clr        (clr),
    .phase_id   (phase_id),
    .phase_valid(phase_valid),
    .fault      (fault),
    .fault_code (fault_code),
    .dwell_cnt  (dwell_cnt),
    .cycle_cnt  (cycle_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input int ph, input int vld, input int flt,
                           input int code, input int dw, input int cyc);
    check({tag, ".phase_id"}, 32'(phase_id), ph);
    check({tag, ".phase_valid"}, 32'(phase_valid), vld);
    check({tag, ".fault"}, 32'(fault), flt);
    check({tag, ".fault_code"}, 32'(fault_code), code);
    check({tag, ".dwell_cnt"}, 32'(dwell_cnt), dw);
    check({tag, ".cycle_cnt"}, 32'(cycle_cnt), cyc);
  endtask

  // Lamp pattern {M1, M2, MT, S} for each phase; R=100, Y=010, G=001.
  function automatic logic [11:0] pat(input int p);
    case (p)
      0:       return {3'b001, 3'b001, 3'b100, 3'b100};
      1:       return {3'b001, 3'b010, 3'b100, 3'b100};
      2:       return {3'b001, 3'b100, 3'b001, 3'b100};
      3:       return {3'b010, 3'b100, 3'b010, 3'b100};
      4:       return {3'b100, 3'b100, 3'b100, 3'b001};
      default: return {3'b100, 3'b100, 3'b100, 3'b010};
    endcase
  endfunction

  // Drive one sample, let it be taken at the next rising edge, then settle.
  task automatic step(input logic [11:0] v, input logic c);
    {light_M1, light_M2, light_MT, light_S} = v;
    clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input int p, input int n);
    for (int i = 0; i < n; i++) step(pat(p), 1'b0);
  endtask

  int dwell_tbl [6] = '{8, 3, 6, 3, 4, 3};
  int fault_seen;
  int invalid_seen;
  int dwell_peak;

  initial begin
    n_chk = 0;
    n_bad = 0;
    rst = 1'b1;
    clr = 1'b0;
    {light_M1, light_M2, light_MT, light_S} = 12'd0;
    #3;
    check_all("reset", 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Three full legal cycles starting in phase 0.
    fault_seen   = 0;
    invalid_seen = 0;
    dwell_peak   = 0;
    for (int c = 0; c < 3; c++) begin
      for (int p = 0; p < 6; p++) begin
        for (int i = 0; i < dwell_tbl[p]; i++) begin
          step(pat(p), 1'b0);
          if (fault) fault_seen++;
          if (!phase_valid) invalid_seen++;
          if (int'(dwell_cnt) > dwell_peak) dwell_peak = int'(dwell_cnt);
        end
      end
    end
    check("cycles.fault_seen", fault_seen, 0);
    check("cycles.invalid_seen", invalid_seen, 0);
    check("cycles.dwell_peak", dwell_peak, 8);
    check_all("cycles.end", 5, 1, 0, 0, 3, 2);

    // Re-enter phase 0 from phase 5, then overstay it.
    step(pat(0), 1'b0);
    check_all("p0.enter", 0, 1, 0, 0, 1, 3);
    hold(0, 7);
    check_all("p0.full", 0, 1, 0, 0, 8, 3);
    step(pat(0), 1'b0);
    check_all("p0.long", 0, 0, 1, 4, 8, 3);

    // clr together with an illegal sample: clr wins.
    step(12'd0, 1'b1);
    check_all("clr1", 0, 0, 0, 0, 0, 3);

    // Out-of-order: phase 1 then phase 3.
    hold(1, 3);
    check_all("order.p1", 1, 1, 0, 0, 3, 3);
    step(pat(3), 1'b0);
    check_all("order.bad", 1, 0, 1, 2, 3, 3);
    step(pat(3), 1'b0);
    check("order.sticky_code", 32'(fault_code), 2);
    step(pat(0), 1'b1);
    check_all("clr2", 1, 0, 0, 0, 0, 3);

    // Short dwell in phase 2 entered from phase 1.
    hold(1, 3);
    hold(2, 5);
    check_all("short.p2", 2, 1, 0, 0, 5, 3);
    step(pat(3), 1'b0);
    check_all("short.bad", 2, 0, 1, 3, 5, 3);
    step(pat(0), 1'b1);

    // Attached mid-phase: a short first phase is tolerated.
    hold(2, 2);
    step(pat(3), 1'b0);
    check_all("first.ok", 3, 1, 0, 0, 1, 3);

    // Non-one-hot M1 during TRACK.
    step({3'b011, 3'b100, 3'b010, 3'b100}, 1'b0);
    check_all("illegal.track", 3, 0, 1, 1, 1, 3);
    step(pat(0), 1'b1);
    step(12'd0, 1'b0);
    check_all("illegal.sync", 3, 0, 1, 1, 0, 3);
    step(pat(0), 1'b1);

    // clr in TRACK is ignored; then async reset mid phase 4.
    hold(4, 1);
    step(pat(4), 1'b1);
    check_all("clr.track", 4, 1, 0, 0, 2, 3);
    #2;
    rst = 1'b1;
    #1;
    check_all("async_rst", 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(pat(5), 1'b0);
    check_all("resume", 5, 1, 0, 0, 1, 0);
    step(pat(0), 1'b0);
    check_all("resume.wrap", 0, 1, 0, 0, 1, 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
